// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: bundle of the request, ShiftUnit and response signals
// around shift_arbiter.
//   req0_*/req1_* : valid/ready request channels (operand, distance, function)
//   su_*          : drive to / result from the external combinational ShiftUnit
//   rsp_*         : registered response slot with valid/ready handshake
// slave  modport : arbiter view
// master modport : environment view (requesters, ShiftUnit, consumer)
interface shift_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SDW   = 5
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [SDW-1:0]   req0_sdist;
   logic [1:0]       req0_sf;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [SDW-1:0]   req1_sdist;
   logic [1:0]       req1_sf;

   logic [WIDTH-1:0] su_a;
   logic [SDW-1:0]   su_sdist;
   logic [1:0]       su_sf;
   logic [WIDTH-1:0] su_sres;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             rsp_err;

   modport slave (
      input  req0_valid, req0_a, req0_sdist, req0_sf,
      input  req1_valid, req1_a, req1_sdist, req1_sf,
      input  su_sres, rsp_ready,
      output req0_ready, req1_ready,
      output su_a, su_sdist, su_sf,
      output rsp_valid, rsp_data, rsp_id, rsp_err
   );

   modport master (
      output req0_valid, req0_a, req0_sdist, req0_sf,
      output req1_valid, req1_a, req1_sdist, req1_sf,
      output su_sres, rsp_ready,
      input  req0_ready, req1_ready,
      input  su_a, su_sdist, su_sf,
      input  rsp_valid, rsp_data, rsp_id, rsp_err
   );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one combinational ShiftUnit between
// two requesters, with a single registered response slot.
//   clk   : rising-edge clock
//   reset : synchronous, active-high, dominant
//   bus   : shift_arbiter_if.slave (request channels, ShiftUnit drive/result,
//           response slot)
// A request is accepted when the slot is free (empty or draining this cycle),
// so one operation per cycle is sustained. Result appears on rsp_* the cycle
// after acceptance. sf=10 is reserved: the response carries data 0, err 1.
module shift_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SDW   = 5
) (
   input logic           clk,
   input logic           reset,
   shift_arbiter_if.slave bus
);

   logic             free;
   logic             grant_vld;
   logic             grant_id;
   logic             reserved;

   logic [WIDTH-1:0] sel_a;
   logic [SDW-1:0]   sel_sdist;
   logic [1:0]       sel_sf;

   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic             rsp_id_q,    rsp_id_d;
   logic             rsp_err_q,   rsp_err_d;
   logic             last_grant_q, last_grant_d;

   assign free = !rsp_valid_q || bus.rsp_ready;

   // Grant is suppressed during reset so nothing is handshaken in that cycle.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (free && !reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
         end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
         end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign bus.req0_ready = grant_vld && !grant_id;
   assign bus.req1_ready = grant_vld &&  grant_id;

   // ShiftUnit inputs follow the granted requester, zero when idle.
   always_comb begin
      sel_a     = '0;
      sel_sdist = '0;
      sel_sf    = '0;
      if (grant_vld) begin
         if (grant_id) begin
            sel_a     = bus.req1_a;
            sel_sdist = bus.req1_sdist;
            sel_sf    = bus.req1_sf;
         end else begin
            sel_a     = bus.req0_a;
            sel_sdist = bus.req0_sdist;
            sel_sf    = bus.req0_sf;
         end
      end
   end

   assign bus.su_a     = sel_a;
   assign bus.su_sdist = sel_sdist;
   assign bus.su_sf    = sel_sf;

   assign reserved = (sel_sf == 2'b10);

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      rsp_err_d    = rsp_err_q;
      last_grant_d = last_grant_q;
      if (grant_vld) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_id;
         last_grant_d = grant_id;
         rsp_data_d   = reserved ? '0 : bus.su_sres;
         rsp_err_d    = reserved;
      end else if (rsp_valid_q && bus.rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         rsp_err_q    <= rsp_err_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: self-checking bench for shift_arbiter. Models the external
// ShiftUnit, drives requests on the falling edge and samples on the falling
// edge. Expected responses are queued when an operation is driven and popped
// when the response slot presents it.
module tb_shift_arbiter;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SDW   = 5;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             id;
      logic             err;
   } rsp_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   rsp_t exp_q[$];
   rsp_t e;

   shift_arbiter_if #(.WIDTH(WIDTH), .SDW(SDW)) bus ();

   shift_arbiter #(.WIDTH(WIDTH), .SDW(SDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ShiftUnit; reserved code returns junk that must never surface.
   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                  input logic [SDW-1:0] sd,
                                                  input logic [1:0] sf);
      case (sf)
         2'b00:   ref_shift = a << sd;
         2'b01:   ref_shift = a >> sd;
         2'b11:   ref_shift = $unsigned($signed(a) >>> sd);
         default: ref_shift = 32'hDEADBEEF;
      endcase
   endfunction

   assign bus.su_sres = ref_shift(bus.su_a, bus.su_sdist, bus.su_sf);

   task automatic set_req(input int r, input logic v, input logic [WIDTH-1:0] a,
                          input logic [SDW-1:0] sd, input logic [1:0] sf);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_sdist = sd; bus.req0_sf = sf;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_sdist = sd; bus.req1_sf = sf;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_req(0, 1'b1, 32'h1, 5'd1, 2'b00);
      set_req(1, 1'b1, 32'h2, 5'd1, 2'b00);
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_rsp: got v=%b d=%h id=%b err=%b, expected all zero",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
      end
      tests++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: got r0=%b r1=%b, expected 0 0", bus.req0_ready, bus.req1_ready);
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      reset = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'h1, 5'd2, 2'b00);
      exp_q.push_back('{32'h4, 1'b0, 1'b0});
      #1;
      tests++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL single_ready: got r0=%b r1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, '0);
      e = exp_q.pop_front();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
         fails++;
         $display("FAIL single_rsp: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
      end
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_drain: got rsp_valid=%b, expected 0", bus.rsp_valid);
      end
   endtask

   task automatic test_contention();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'h00000010, 5'd3, 2'b01);
      set_req(1, 1'b1, 32'hFFFFFFE0, 5'd3, 2'b11);
      exp_q.push_back('{32'h00000002, 1'b0, 1'b0});
      exp_q.push_back('{32'hFFFFFFFC, 1'b1, 1'b0});
      #1;
      tests++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL contention_first_grant: got r0=%b r1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
      end
      for (int unsigned i = 0; i < 2; i++) begin
         @(negedge clk);
         set_req(int'(i), 1'b0, '0, '0, '0);
         e = exp_q.pop_front();
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
            fails++;
            $display("FAIL contention_rsp%0d: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
         end
         if (i == 0) begin
            #1;
            tests++;
            if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
               fails++;
               $display("FAIL contention_second_grant: got r0=%b r1=%b, expected 0 1", bus.req0_ready, bus.req1_ready);
            end
         end
      end
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL contention_drain: got rsp_valid=%b, expected 0", bus.rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      rsp_t held;
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'h3, 5'd4, 2'b00);
      exp_q.push_back('{32'h30, 1'b0, 1'b0});
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, '0);
      bus.rsp_ready = 1'b0;
      set_req(1, 1'b1, 32'h5, 5'd1, 2'b00);
      exp_q.push_back('{32'hA, 1'b1, 1'b0});
      held = exp_q.pop_front();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held.data || bus.rsp_id !== held.id) begin
         fails++;
         $display("FAIL bp_first_rsp: got v=%b d=%h id=%b, expected v=1 d=%h id=%b",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, held.data, held.id);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_stall%0d: got r0=%b r1=%b, expected 0 0", i, bus.req0_ready, bus.req1_ready);
         end
         @(negedge clk);
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held.data || bus.rsp_id !== held.id) begin
            fails++;
            $display("FAIL bp_hold%0d: got v=%b d=%h id=%b, expected v=1 d=%h id=%b",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, held.data, held.id);
         end
      end
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_release_ready: got r0=%b r1=%b, expected 0 1", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      set_req(1, 1'b0, '0, '0, '0);
      e = exp_q.pop_front();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
         fails++;
         $display("FAIL bp_next_rsp: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
      end
      @(negedge clk);
   endtask

   task automatic test_reserved();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(1, 1'b1, 32'h12345678, 5'd4, 2'b10);
      exp_q.push_back('{32'h0, 1'b1, 1'b1});
      @(negedge clk);
      set_req(1, 1'b1, 32'h1, 5'd1, 2'b00);
      exp_q.push_back('{32'h2, 1'b1, 1'b0});
      for (int unsigned i = 0; i < 2; i++) begin
         if (i == 1) begin
            @(negedge clk);
            set_req(1, 1'b0, '0, '0, '0);
         end
         e = exp_q.pop_front();
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
            fails++;
            $display("FAIL reserved_rsp%0d: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_extremes();
      logic [WIDTH-1:0] a_v  [3] = '{32'hA5A5A5A5, 32'h80000000, 32'h80000000};
      logic [SDW-1:0]   sd_v [3] = '{5'd0, 5'd31, 5'd31};
      logic [1:0]       sf_v [3] = '{2'b01, 2'b11, 2'b01};
      logic [WIDTH-1:0] ex_v [3] = '{32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000001};
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
               fails++;
               $display("FAIL extreme%0d: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                        i - 1, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
            end
         end
         if (i < 3) begin
            set_req(0, 1'b1, a_v[i], sd_v[i], sf_v[i]);
            exp_q.push_back('{ex_v[i], 1'b0, 1'b0});
         end else begin
            set_req(0, 1'b0, '0, '0, '0);
         end
         @(negedge clk);
      end
   endtask

   // Both requesters always valid: grants must alternate starting opposite
   // to the last granted requester (0, from the extremes test).
   task automatic test_back_to_back();
      logic             lg;
      logic             g;
      logic [1:0]       sfs [3] = '{2'b00, 2'b01, 2'b11};
      logic [WIDTH-1:0] fa  [2];
      logic [SDW-1:0]   fd  [2];
      logic [1:0]       ff  [2];
      lg = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int unsigned r = 0; r < 2; r++) begin
         fa[r] = $urandom;
         fd[r] = SDW'($urandom_range(31, 0));
         ff[r] = sfs[$urandom_range(2, 0)];
         set_req(int'(r), 1'b1, fa[r], fd[r], ff[r]);
      end
      for (int unsigned i = 0; i < 8; i++) begin
         g = ~lg;
         exp_q.push_back('{ref_shift(fa[g], fd[g], ff[g]), g, 1'b0});
         #1;
         tests++;
         if (bus.req0_ready !== !g || bus.req1_ready !== g) begin
            fails++;
            $display("FAIL b2b_grant%0d: got r0=%b r1=%b, expected grant %0d", i, bus.req0_ready, bus.req1_ready, g);
         end
         @(negedge clk);
         e = exp_q.pop_front();
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
            fails++;
            $display("FAIL b2b_rsp%0d: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
         end
         lg = g;
         fa[g] = $urandom;
         fd[g] = SDW'($urandom_range(31, 0));
         ff[g] = sfs[$urandom_range(2, 0)];
         set_req(int'(g), 1'b1, fa[g], fd[g], ff[g]);
      end
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, 32'h1, 5'd5, 2'b00);
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h20) begin
         fails++;
         $display("FAIL rmid_pending: got v=%b d=%h, expected v=1 d=00000020", bus.rsp_valid, bus.rsp_data);
      end
      reset = 1'b1;
      set_req(0, 1'b1, 32'h7, 5'd1, 2'b00);
      set_req(1, 1'b1, 32'h9, 5'd2, 2'b00);
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL rmid_ready_in_reset: got r0=%b r1=%b, expected 0 0", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL rmid_cleared: got v=%b d=%h id=%b err=%b, expected all zero",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
      end
      reset = 1'b0;
      exp_q.push_back('{32'hE, 1'b0, 1'b0});
      #1;
      tests++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL rmid_first_grant: got r0=%b r1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      e = exp_q.pop_front();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
         fails++;
         $display("FAIL rmid_rsp: got v=%b d=%h id=%b err=%b, expected v=1 d=%h id=%b err=%b",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
      end
      @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reserved();
      test_extremes();
      test_back_to_back();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_empty: got %0d leftover entries, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
